// File: rtl/rv_instr_chk_pkg.sv
// Shared opcode, error-index and cause encodings for the RV32/RV64 illegal-instruction checker.
package rv_instr_chk_pkg;

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;

    localparam int unsigned ERR_OPC = 0;
    localparam int unsigned ERR_F3  = 1;
    localparam int unsigned ERR_FN7 = 2;

    localparam logic [1:0] CAUSE_OPC = 2'd0;
    localparam logic [1:0] CAUSE_F3  = 2'd1;
    localparam logic [1:0] CAUSE_FN7 = 2'd2;

    // Cause is the index of the lowest set error bit.
    function automatic logic [1:0] err_cause(input logic [2:0] err);
        if (err[ERR_OPC]) return CAUSE_OPC;
        else if (err[ERR_F3]) return CAUSE_F3;
        else return CAUSE_FN7;
    endfunction

endpackage

// File: rtl/rv_instr_classify.sv
// Combinational RV32/RV64 base-ISA legality classifier returning {funct7/shamt, funct3, opcode}.
// Macro RV_M_EXT_EN makes the M-extension funct7=0000001 encodings legal.
module rv_instr_classify
    import rv_instr_chk_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] i_instr,
    output logic [2:0]  o_err
);

    localparam bit IS64 = (XLEN == 64);

    logic [4:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [5:0] w_hi6;
    logic       w_opc_bad, w_f3_bad, w_fn7_bad;
    logic       w_shamt32_bad, w_shamt64_bad, w_alt_ok, w_w_f3_ok;
    logic       w_mul_ok, w_mulw_ok, w_op_f7_bad, w_op32_f7_bad;
    logic       w_unused;

    assign w_op  = i_instr[6:2];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_hi6 = i_instr[31:26];
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    assign w_shamt32_bad = (w_f3 == 3'b001 && w_f7 != 7'b0000000) ||
                           (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000);
    assign w_shamt64_bad = (w_f3 == 3'b001 && w_hi6 != 6'b000000) ||
                           (w_f3 == 3'b101 && w_hi6 != 6'b000000 && w_hi6 != 6'b010000);
    assign w_alt_ok      = (w_f3 == 3'b000) || (w_f3 == 3'b101);
    assign w_w_f3_ok     = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b101);

`ifdef RV_M_EXT_EN
    assign w_mul_ok  = 1'b1;
    assign w_mulw_ok = (w_f3 == 3'b000) || w_f3[2];
`else
    assign w_mul_ok  = 1'b0;
    assign w_mulw_ok = 1'b0;
`endif

    assign w_op_f7_bad   = !((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000 && w_alt_ok) ||
                             (w_f7 == 7'b0000001 && w_mul_ok));
    assign w_op32_f7_bad = !((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000 && w_alt_ok) ||
                             (w_f7 == 7'b0000001 && w_mulw_ok));

    always_comb begin
        w_opc_bad = 1'b0;
        w_f3_bad  = 1'b0;
        w_fn7_bad = 1'b0;
        case (w_op)
            OPC_LUI, OPC_AUIPC, OPC_JAL: ;
            OPC_JALR:   w_f3_bad = (w_f3 != 3'b000);
            OPC_BRANCH: w_f3_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            OPC_LOAD:   w_f3_bad = (w_f3 == 3'b111) ||
                                   (!IS64 && (w_f3 == 3'b011 || w_f3 == 3'b110));
            OPC_STORE:  w_f3_bad = w_f3[2] || (!IS64 && w_f3 == 3'b011);
            OPC_OP_IMM: w_fn7_bad = IS64 ? w_shamt64_bad : w_shamt32_bad;
            OPC_OP:     w_fn7_bad = w_op_f7_bad;
            OPC_OP_IMM_32: begin
                if (IS64) begin
                    w_f3_bad  = !w_w_f3_ok;
                    w_fn7_bad = w_shamt32_bad;
                end else begin
                    w_opc_bad = 1'b1;
                end
            end
            OPC_OP_32: begin
                if (IS64) begin
                    // M-extension word ops reuse f3 values otherwise illegal on OP-32.
                    w_f3_bad  = !w_w_f3_ok && !(w_f7 == 7'b0000001 && w_mulw_ok);
                    w_fn7_bad = w_op32_f7_bad;
                end else begin
                    w_opc_bad = 1'b1;
                end
            end
            default: w_opc_bad = 1'b1;
        endcase
        if (i_instr[1:0] != 2'b11) w_opc_bad = 1'b1;
    end

    assign o_err = w_opc_bad ? 3'b001 : {w_fn7_bad, w_f3_bad, 1'b0};

endmodule

// File: rtl/rv_instr_checker.sv
// Registered illegal-instruction checker: handshake stage, sticky first-fault capture and
// saturating per-class counters. Optional M-extension legality via macro RV_M_EXT_EN.
module rv_instr_checker
    import rv_instr_chk_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_err,
    output logic             out_illegal,
    input  logic             clr,
    output logic             fault_valid,
    output logic [XLEN-1:0]  fault_pc,
    output logic [31:0]      fault_instr,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] cnt_opc,
    output logic [CNT_W-1:0] cnt_f3,
    output logic [CNT_W-1:0] cnt_fn7
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_in_ready, w_accept, w_fault_load;
    logic [2:0]       w_err;
    logic             r_out_valid;
    logic [31:0]      r_out_instr;
    logic [2:0]       r_out_err;
    logic             r_fault_valid;
    logic [XLEN-1:0]  r_fault_pc;
    logic [31:0]      r_fault_instr;
    logic [1:0]       r_fault_cause;
    logic [CNT_W-1:0] r_cnt   [3];
    logic [CNT_W-1:0] w_cnt_nxt [3];

    rv_instr_classify #(
        .XLEN (XLEN)
    ) u_classify (
        .i_instr (in_instr),
        .o_err   (w_err)
    );

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_instr <= in_instr;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // clr acts before a same-edge fault, so the new fault is captured rather than dropped.
    assign w_fault_load = w_accept && (|w_err) && (clr || !r_fault_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_valid <= 1'b0;
            r_fault_pc    <= '0;
            r_fault_instr <= '0;
            r_fault_cause <= '0;
        end else if (w_fault_load) begin
            r_fault_valid <= 1'b1;
            r_fault_pc    <= in_pc;
            r_fault_instr <= in_instr;
            r_fault_cause <= err_cause(w_err);
        end else if (clr) begin
            r_fault_valid <= 1'b0;
            r_fault_pc    <= '0;
            r_fault_instr <= '0;
            r_fault_cause <= '0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_cnt_nxt[i] = clr ? '0 : r_cnt[i];
            if (w_accept && w_err[i] && w_cnt_nxt[i] != CNT_MAX) begin
                w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_instr   = r_out_instr;
    assign out_err     = r_out_err;
    assign out_illegal = |r_out_err;
    assign fault_valid = r_fault_valid;
    assign fault_pc    = r_fault_pc;
    assign fault_instr = r_fault_instr;
    assign fault_cause = r_fault_cause;
    assign cnt_opc     = r_cnt[ERR_OPC];
    assign cnt_f3      = r_cnt[ERR_F3];
    assign cnt_fn7     = r_cnt[ERR_FN7];

endmodule

// File: tb/tb_rv_instr_checker.sv
// Directed bench for rv_instr_checker: an RV32 (CNT_W=2) and an RV64 (CNT_W=8) instance
// share the same stimulus.
module tb_rv_instr_checker;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal, a_fault_valid;
    logic [31:0] a_out_instr, a_fault_instr, a_fault_pc;
    logic [2:0]  a_out_err;
    logic [1:0]  a_fault_cause, a_cnt_opc, a_cnt_f3, a_cnt_fn7;

    logic        b_in_ready, b_out_valid, b_out_illegal, b_fault_valid;
    logic [31:0] b_out_instr, b_fault_instr;
    logic [63:0] b_fault_pc;
    logic [2:0]  b_out_err;
    logic [1:0]  b_fault_cause;
    logic [7:0]  b_cnt_opc, b_cnt_f3, b_cnt_fn7;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv_instr_checker #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_instr(a_out_instr), .out_err(a_out_err),
        .out_illegal(a_out_illegal), .clr(clr), .fault_valid(a_fault_valid),
        .fault_pc(a_fault_pc), .fault_instr(a_fault_instr), .fault_cause(a_fault_cause),
        .cnt_opc(a_cnt_opc), .cnt_f3(a_cnt_f3), .cnt_fn7(a_cnt_fn7)
    );

    rv_instr_checker #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_instr(b_out_instr), .out_err(b_out_err),
        .out_illegal(b_out_illegal), .clr(clr), .fault_valid(b_fault_valid),
        .fault_pc(b_fault_pc), .fault_instr(b_fault_instr), .fault_cause(b_fault_cause),
        .cnt_opc(b_cnt_opc), .cnt_f3(b_cnt_f3), .cnt_fn7(b_cnt_fn7)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        in_instr = 32'h0; in_pc = 64'h0;
        step(); step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0h want 0", a_out_valid); end
        n_tests++; if (a_out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", a_out_instr); end
        n_tests++; if (a_out_err !== 3'b000) begin n_fail++; $display("FAIL reset_out_err got %b want 000", a_out_err); end
        n_tests++; if (a_fault_valid !== 1'b0 || a_fault_pc !== 32'h0 || a_fault_instr !== 32'h0 || a_fault_cause !== 2'd0) begin
            n_fail++; $display("FAIL reset_fault got v=%0h pc=%h i=%h c=%0d want all 0", a_fault_valid, a_fault_pc, a_fault_instr, a_fault_cause); end
        n_tests++; if ({a_cnt_opc, a_cnt_f3, a_cnt_fn7} !== 6'h0 || {b_cnt_opc, b_cnt_f3, b_cnt_fn7} !== 24'h0) begin
            n_fail++; $display("FAIL reset_counters got %h/%h want 0", {a_cnt_opc, a_cnt_f3, a_cnt_fn7}, {b_cnt_opc, b_cnt_f3, b_cnt_fn7}); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0h want 1", a_in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_legal_stream();
        in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 64'h0;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h13 || a_out_err !== 3'b000) begin
            n_fail++; $display("FAIL legal_c1 got v=%0h i=%h e=%b want 1/00000013/000", a_out_valid, a_out_instr, a_out_err); end
        in_instr = 32'h0000_8067; in_pc = 64'h4;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h8067 || a_out_err !== 3'b000 || a_out_illegal !== 1'b0) begin
            n_fail++; $display("FAIL legal_c2 got v=%0h i=%h e=%b want 1/00008067/000", a_out_valid, a_out_instr, a_out_err); end
        in_valid = 1'b0;
        step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL legal_drain got %0h want 0", a_out_valid); end
        n_tests++; if (a_fault_valid !== 1'b0 || {a_cnt_opc, a_cnt_f3, a_cnt_fn7} !== 6'h0) begin
            n_fail++; $display("FAIL legal_no_fault got v=%0h cnt=%h want 0", a_fault_valid, {a_cnt_opc, a_cnt_f3, a_cnt_fn7}); end
    endtask

    task automatic test_bad_f3();
        in_valid = 1'b1; in_instr = 32'h0000_1067; in_pc = 64'h100;
        step();
        in_valid = 1'b0;
        n_tests++; if (a_out_err !== 3'b010 || a_out_illegal !== 1'b1) begin n_fail++; $display("FAIL badf3_err got %b want 010", a_out_err); end
        n_tests++; if (a_fault_valid !== 1'b1 || a_fault_pc !== 32'h100 || a_fault_cause !== 2'd1) begin
            n_fail++; $display("FAIL badf3_fault got v=%0h pc=%h c=%0d want 1/100/1", a_fault_valid, a_fault_pc, a_fault_cause); end
        n_tests++; if (a_cnt_f3 !== 2'd1 || b_cnt_f3 !== 8'd1) begin n_fail++; $display("FAIL badf3_cnt got %0d/%0d want 1", a_cnt_f3, b_cnt_f3); end
        step();
    endtask

    task automatic test_bad_opc_hold();
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++; if (a_fault_valid !== 1'b0 || a_cnt_f3 !== 2'd0) begin
            n_fail++; $display("FAIL clr_idle got v=%0h f3cnt=%0d want 0/0", a_fault_valid, a_cnt_f3); end
        in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 64'h200;
        step();
        n_tests++; if (a_out_err !== 3'b001 || a_fault_instr !== 32'h7F || a_fault_cause !== 2'd0) begin
            n_fail++; $display("FAIL badopc got e=%b fi=%h c=%0d want 001/0000007f/0", a_out_err, a_fault_instr, a_fault_cause); end
        in_instr = 32'h0000_1067; in_pc = 64'h204;
        step();
        in_valid = 1'b0;
        n_tests++; if (a_fault_instr !== 32'h7F || a_fault_pc !== 32'h200 || b_fault_instr !== 32'h7F) begin
            n_fail++; $display("FAIL fault_hold got %h pc=%h want 0000007f pc=200", a_fault_instr, a_fault_pc); end
        n_tests++; if (a_cnt_opc !== 2'd1 || a_cnt_f3 !== 2'd1) begin
            n_fail++; $display("FAIL hold_cnt got opc=%0d f3=%0d want 1/1", a_cnt_opc, a_cnt_f3); end
        step();
    endtask

    task automatic test_xlen();
        in_valid = 1'b1; in_instr = 32'h0200_1013;
        step();
        n_tests++; if (a_out_err !== 3'b100 || b_out_err !== 3'b000) begin
            n_fail++; $display("FAIL xlen_slli got rv32=%b rv64=%b want 100/000", a_out_err, b_out_err); end
        in_instr = 32'h0000_001B;
        step();
        in_valid = 1'b0;
        n_tests++; if (a_out_err !== 3'b001 || b_out_err !== 3'b000) begin
            n_fail++; $display("FAIL xlen_addiw got rv32=%b rv64=%b want 001/000", a_out_err, b_out_err); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093;
        step();
        in_instr = 32'h0020_0113;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h0010_0093 || a_in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%0h i=%h rdy=%0h want 1/00100093/0", i, a_out_valid, a_out_instr, a_in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %0h want 1", a_in_ready); end
        step();
        n_tests++; if (a_out_instr !== 32'h0020_0113 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_second got %h want 00200113", a_out_instr); end
        in_instr = 32'h0030_0193;
        step();
        in_valid = 1'b0;
        n_tests++; if (a_out_instr !== 32'h0030_0193 || a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_third got %h want 00300193", a_out_instr); end
        step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0h want 0", a_out_valid); end
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        step();
        clr = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 64'h280;
        repeat (5) step();
        in_valid = 1'b0;
        step();
        n_tests++; if (a_cnt_opc !== 2'd3 || b_cnt_opc !== 8'd5) begin
            n_fail++; $display("FAIL sat_cnt got rv32=%0d rv64=%0d want 3/5", a_cnt_opc, b_cnt_opc); end
    endtask

    task automatic test_clr_collision();
        clr = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 64'h300;
        step();
        clr = 1'b0; in_valid = 1'b0;
        n_tests++; if (a_cnt_opc !== 2'd1 || b_cnt_opc !== 8'd1 || a_cnt_f3 !== 2'd0) begin
            n_fail++; $display("FAIL clr_col_cnt got opc=%0d/%0d f3=%0d want 1/1/0", a_cnt_opc, b_cnt_opc, a_cnt_f3); end
        n_tests++; if (a_fault_valid !== 1'b1 || a_fault_pc !== 32'h300 || b_fault_pc !== 64'h300) begin
            n_fail++; $display("FAIL clr_col_fault got v=%0h pc=%h want 1/300", a_fault_valid, a_fault_pc); end
        n_tests++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h7F || a_out_err !== 3'b001) begin
            n_fail++; $display("FAIL clr_col_pipe got v=%0h i=%h e=%b want 1/0000007f/001", a_out_valid, a_out_instr, a_out_err); end
        step();
    endtask

    task automatic test_m_ext();
        logic [2:0] exp_err;
`ifdef RV_M_EXT_EN
        exp_err = 3'b000;
`else
        exp_err = 3'b100;
`endif
        in_valid = 1'b1; in_instr = 32'h0200_0033;
        step();
        in_valid = 1'b0;
        n_tests++; if (a_out_err !== exp_err || b_out_err !== exp_err) begin
            n_fail++; $display("FAIL m_ext got rv32=%b rv64=%b want %b", a_out_err, b_out_err, exp_err); end
        step();
    endtask

    initial begin
        test_reset();
        test_legal_stream();
        test_bad_f3();
        test_bad_opc_hold();
        test_xlen();
        test_backpressure();
        test_saturation();
        test_clr_collision();
        test_m_ext();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
